// File: rtl/param_register_file.sv
// Parametrised register file: two combinational read ports, one write port,
// per-register busy scoreboard and a sequential clear engine run after reset.
module param_register_file #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1,
    parameter int BYPASS     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  RegWrite,
    input  logic [ADDR_WIDTH-1:0] write_address,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic                  reserve_en,
    input  logic [ADDR_WIDTH-1:0] reserve_addr,
    input  logic [ADDR_WIDTH-1:0] read_sel_1,
    input  logic [ADDR_WIDTH-1:0] read_sel_2,
    output logic [DATA_WIDTH-1:0] read_data_1,
    output logic [DATA_WIDTH-1:0] read_data_2,
    output logic                  read_busy_1,
    output logic                  read_busy_2,
    output logic                  ready
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    typedef enum logic {CLEAR, READY} state_t;

    state_t                  state;
    logic [ADDR_WIDTH-1:0]   clr_idx;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DEPTH-1:0]        busy;

    // Register 0 is read-only (and never busy) when the zero register is enabled.
    function automatic logic writable(input logic [ADDR_WIDTH-1:0] addr);
        return !((ZERO_REG != 0) && (addr == '0));
    endfunction

    // Returns {busy, data} for one read port.
    function automatic logic [DATA_WIDTH:0] read_port(input logic [ADDR_WIDTH-1:0] sel);
        logic [DATA_WIDTH-1:0] d;
        logic                  b;
        d = '0;
        b = 1'b0;
        if (state == READY && writable(sel)) begin
            d = mem[sel];
            b = busy[sel];
            if ((BYPASS != 0) && RegWrite && (write_address == sel)) begin
                d = write_data;
                if (!(reserve_en && (reserve_addr == sel)))
                    b = 1'b0;
            end
        end
        return {b, d};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            clr_idx <= '0;
            busy    <= '0;
            ready   <= 1'b0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_idx <= clr_idx + 1'b1;
                    if (clr_idx == {ADDR_WIDTH{1'b1}}) begin
                        state <= READY;
                        ready <= 1'b1;
                    end
                end
                READY: begin
                    if (RegWrite && writable(write_address))
                        busy[write_address] <= 1'b0;
                    // Reserve is applied last: it belongs to a newer producer.
                    if (reserve_en && writable(reserve_addr))
                        busy[reserve_addr] <= 1'b1;
                end
                default: state <= CLEAR;
            endcase
        end
    end

    // Storage holds data only, so it is zeroed by the clear engine rather than by rst.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR)
                mem[clr_idx] <= '0;
            else if (RegWrite && writable(write_address))
                mem[write_address] <= write_data;
        end
    end

    always_comb begin
        {read_busy_1, read_data_1} = read_port(read_sel_1);
        {read_busy_2, read_data_2} = read_port(read_sel_2);
    end

endmodule

// File: tb/tb_param_register_file.sv
// Bench for param_register_file: one instance with zero register and bypass,
// one without either, both checked every cycle against an array-based model.
module tb_param_register_file;

    logic        clk = 1'b0;
    logic        rst;
    logic        RegWrite;
    logic [4:0]  write_address;
    logic [31:0] write_data;
    logic        reserve_en;
    logic [4:0]  reserve_addr;
    logic [4:0]  read_sel_1;
    logic [4:0]  read_sel_2;
    logic [31:0] rd1 [2];
    logic [31:0] rd2 [2];
    logic        rb1 [2];
    logic        rb2 [2];
    logic        rdy [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .write_address(write_address),
        .write_data(write_data), .reserve_en(reserve_en), .reserve_addr(reserve_addr),
        .read_sel_1(read_sel_1), .read_sel_2(read_sel_2),
        .read_data_1(rd1[0]), .read_data_2(rd2[0]),
        .read_busy_1(rb1[0]), .read_busy_2(rb2[0]), .ready(rdy[0]));

    param_register_file #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst), .RegWrite(RegWrite), .write_address(write_address),
        .write_data(write_data), .reserve_en(reserve_en), .reserve_addr(reserve_addr),
        .read_sel_1(read_sel_1), .read_sel_2(read_sel_2),
        .read_data_1(rd1[1]), .read_data_2(rd2[1]),
        .read_busy_1(rb1[1]), .read_busy_2(rb2[1]), .ready(rdy[1]));

    // Reference model: per-instance register contents and busy flags, plus the
    // number of edges seen since reset was released.
    logic [31:0] m_mem  [2][32];
    logic        m_busy [2][32];
    int          m_cnt;
    bit          m_zr [2] = '{1'b1, 1'b0};
    bit          m_bp [2] = '{1'b1, 1'b0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    function automatic void exp_read(input int i, input logic [4:0] sel,
                                     output logic [31:0] d, output logic b);
        d = '0;
        b = 1'b0;
        if (m_cnt >= 32 && !(m_zr[i] && sel == 5'd0)) begin
            d = m_mem[i][sel];
            b = m_busy[i][sel];
            if (m_bp[i] && RegWrite && write_address == sel) begin
                d = write_data;
                if (!(reserve_en && reserve_addr == sel)) b = 1'b0;
            end
        end
    endfunction

    task automatic model_edge();
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int a = 0; a < 32; a++) begin
                    m_mem[i][a]  = '0;
                    m_busy[i][a] = 1'b0;
                end
            end else if (m_cnt >= 32) begin
                if (RegWrite && !(m_zr[i] && write_address == 5'd0)) begin
                    m_mem[i][write_address]  = write_data;
                    m_busy[i][write_address] = 1'b0;
                end
                if (reserve_en && !(m_zr[i] && reserve_addr == 5'd0))
                    m_busy[i][reserve_addr] = 1'b1;
            end
        end
        if (rst) m_cnt = 0;
        else if (m_cnt < 32) m_cnt++;
    endtask

    task automatic check_outputs();
        logic [31:0] d;
        logic        b;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ready[%0d]", i), {31'd0, rdy[i]}, {31'd0, (m_cnt >= 32)});
            exp_read(i, read_sel_1, d, b);
            chk($sformatf("rdata1[%0d] sel=%0d", i, read_sel_1), rd1[i], d);
            chk($sformatf("rbusy1[%0d] sel=%0d", i, read_sel_1), {31'd0, rb1[i]}, {31'd0, b});
            exp_read(i, read_sel_2, d, b);
            chk($sformatf("rdata2[%0d] sel=%0d", i, read_sel_2), rd2[i], d);
            chk($sformatf("rbusy2[%0d] sel=%0d", i, read_sel_2), {31'd0, rb2[i]}, {31'd0, b});
        end
    endtask

    // Entered 1 time unit after a rising edge with inputs already set.
    task automatic cycle();
        #2;
        check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        RegWrite = 1'b0; write_address = '0; write_data = '0;
        reserve_en = 1'b0; reserve_addr = '0;
    endtask

    task automatic run_until_ready(input bit noisy, output int edges);
        edges = 0;
        while (!rdy[0] && edges < 40) begin
            if (noisy) begin
                RegWrite      = 1'b1;
                write_address = 5'($urandom);
                write_data    = $urandom;
                reserve_en    = 1'b1;
                reserve_addr  = 5'($urandom);
                read_sel_1    = 5'($urandom);
                read_sel_2    = 5'($urandom);
            end
            cycle();
            edges++;
        end
        idle();
    endtask

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        re;
        logic [4:0]  ra;
        logic [4:0]  s1;
        logic [31:0] ed;
        logic        eb;
    } vec_t;

    vec_t tbl [11];

    initial begin
        int edges;

        tbl[0]  = '{1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0};
        tbl[1]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd5, 32'hDEADBEEF, 1'b0};
        tbl[2]  = '{1'b1, 5'd0, 32'h12345678, 1'b0, 5'd0, 5'd0, 32'h0,        1'b0};
        tbl[3]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd0, 5'd0, 32'h0,        1'b0};
        tbl[4]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd0, 32'h0,        1'b0};
        tbl[5]  = '{1'b0, 5'd0, 32'h0,        1'b1, 5'd7, 5'd7, 32'h0,        1'b0};
        tbl[6]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 32'h0,        1'b1};
        tbl[7]  = '{1'b1, 5'd7, 32'hA5,       1'b0, 5'd0, 5'd7, 32'hA5,       1'b0};
        tbl[8]  = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 32'hA5,       1'b0};
        tbl[9]  = '{1'b1, 5'd7, 32'hA5,       1'b1, 5'd7, 5'd7, 32'hA5,       1'b0};
        tbl[10] = '{1'b0, 5'd0, 32'h0,        1'b0, 5'd0, 5'd7, 32'hA5,       1'b1};

        idle();
        read_sel_1 = '0; read_sel_2 = '0;
        m_cnt = 0;
        rst = 1'b1;
        @(posedge clk);
        model_edge();
        #1;
        chk("reset ready", {31'd0, rdy[0]}, 32'd0);
        chk("reset rdata1", rd1[0], 32'd0);

        // Initial clear with quiet inputs.
        rst = 1'b0;
        read_sel_1 = 5'd1; read_sel_2 = 5'd31;
        run_until_ready(1'b0, edges);
        chk("clear edges", edges, 32'd32);
        for (int a = 0; a < 32; a++) begin
            read_sel_1 = 5'(a); read_sel_2 = 5'(31 - a);
            cycle();
        end

        // Directed write/bypass, zero register and scoreboard vectors.
        for (int k = 0; k < 11; k++) begin
            RegWrite = tbl[k].we; write_address = tbl[k].wa; write_data = tbl[k].wd;
            reserve_en = tbl[k].re; reserve_addr = tbl[k].ra;
            read_sel_1 = tbl[k].s1; read_sel_2 = 5'd7;
            #2;
            chk($sformatf("vec%0d data", k), rd1[0], tbl[k].ed);
            chk($sformatf("vec%0d busy", k), {31'd0, rb1[0]}, {31'd0, tbl[k].eb});
            if (k == 0) chk("nobypass old value", rd1[1], 32'h0);
            if (k == 1) chk("nobypass new value", rd1[1], 32'hDEADBEEF);
            cycle();
        end
        idle();

        // Reset in the middle of operation and again partway through a clear.
        RegWrite = 1'b1; write_address = 5'd3; write_data = 32'h55;
        cycle();
        idle();
        reserve_en = 1'b1; reserve_addr = 5'd9;
        cycle();
        idle();
        read_sel_1 = 5'd3; read_sel_2 = 5'd9;
        #2;
        chk("mid data3", rd1[0], 32'h55);
        chk("mid busy9", {31'd0, rb2[0]}, 32'd1);
        cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        // Writes and reservations during this clear must have no effect.
        run_until_ready(1'b1, edges);
        chk("restart edges", edges, 32'd32);
        read_sel_1 = 5'd3; read_sel_2 = 5'd9;
        #2;
        chk("after clear data3", rd1[0], 32'h0);
        chk("after clear busy9", {31'd0, rb2[0]}, 32'd0);
        cycle();
        for (int a = 0; a < 32; a++) begin
            read_sel_1 = 5'(a); read_sel_2 = 5'(a);
            #2;
            chk($sformatf("post-clear b data %0d", a), rd1[1], 32'h0);
            chk($sformatf("post-clear b busy %0d", a), {31'd0, rb2[1]}, 32'd0);
            cycle();
        end

        // Randomised traffic with collisions and occasional reset.
        for (int c = 0; c < 600; c++) begin
            rst           = ($urandom_range(0, 299) == 0);
            RegWrite      = $urandom_range(0, 1) == 1;
            reserve_en    = $urandom_range(0, 2) == 0;
            write_address = 5'($urandom_range(0, 7));
            reserve_addr  = 5'($urandom_range(0, 7));
            read_sel_1    = 5'($urandom_range(0, 7));
            read_sel_2    = ($urandom_range(0, 1) == 1) ? write_address : 5'($urandom);
            write_data    = $urandom;
            cycle();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
